// File: rtl/pipelined_add_sub_cla.sv
// N-bit add/sub from GROUP-bit CLA slices, one slice per stage; latency WIDTH/GROUP, stalls freeze every stage.
// Optional ADDSUB_SAT_EN saturates the result on signed overflow in the output stage.
module pipelined_add_sub_cla #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int L = WIDTH / GROUP;

  // Returns {carry_out, carry_into_msb, sum} with every carry expanded as a lookahead term.
  function automatic logic [GROUP+1:0] cla(input logic [GROUP-1:0] x,
                                           input logic [GROUP-1:0] y,
                                           input logic ci);
    logic [GROUP-1:0] g, p;
    logic [GROUP:0]   c;
    logic             pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int k = i - 1; k >= 0; k--) begin
        c[i+1] = c[i+1] | (pp & g[k]);
        pp     = pp & p[k];
      end
      c[i+1] = c[i+1] | (pp & ci);
    end
    return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
  endfunction

  logic             adv;
  logic [L-1:0]     vld_q, vld_d;
  logic [L-1:0]     c_q, c_d;
  logic [WIDTH-1:0] a_q [L];
  logic [WIDTH-1:0] a_d [L];
  logic [WIDTH-1:0] b_q [L];
  logic [WIDTH-1:0] b_d [L];
  logic [WIDTH-1:0] sum_q [L];
  logic [WIDTH-1:0] sum_d [L];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [GROUP+1:0] slice;
  logic [GROUP+1:0] fin;
  logic [WIDTH-1:0] s_raw, s_fin;
  logic             ovf_raw;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d       = vld_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    slice       = '0;

    fin     = cla(a_q[L-1][WIDTH-GROUP +: GROUP], b_q[L-1][WIDTH-GROUP +: GROUP], c_q[L-1]);
    s_raw   = sum_q[L-1];
    s_raw[WIDTH-GROUP +: GROUP] = fin[GROUP-1:0];
    ovf_raw = fin[GROUP+1] ^ fin[GROUP];
    s_fin   = s_raw;
`ifdef ADDSUB_SAT_EN
    // A negative-looking wrapped result means positive overflow, and vice versa.
    if (ovf_raw)
      s_fin = s_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif

    if (adv) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        a_d[0]   = a;
        b_d[0]   = ctrl ? ~b : b;
        c_d[0]   = cin ^ ctrl;
        sum_d[0] = '0;
      end
      for (int j = 1; j < L; j++) begin
        slice    = cla(a_q[j-1][(j-1)*GROUP +: GROUP], b_q[j-1][(j-1)*GROUP +: GROUP], c_q[j-1]);
        vld_d[j] = vld_q[j-1];
        a_d[j]   = a_q[j-1];
        b_d[j]   = b_q[j-1];
        sum_d[j] = sum_q[j-1];
        sum_d[j][(j-1)*GROUP +: GROUP] = slice[GROUP-1:0];
        c_d[j]   = slice[GROUP+1];
      end
      out_valid_d = vld_q[L-1];
      s_d         = s_fin;
      cout_d      = fin[GROUP+1];
      ovf_d       = ovf_raw;
      zero_d      = (s_fin == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      c_q         <= '0;
      for (int j = 0; j < L; j++) begin
        a_q[j]   <= '0;
        b_q[j]   <= '0;
        sum_q[j] <= '0;
      end
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_add_sub_cla.sv
// Directed and random checks of pipelined_add_sub_cla at WIDTH=16, GROUP=4.
module tb_pipelined_add_sub_cla;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, ctrl;
  logic        out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, s;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  res_t q[$];
  int   checks = 0, failures = 0;
  int   cyc, out_cnt, first_out, last_out, acc;
  logic accepted;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] OVF_ADD_S = 16'h7FFF;
  localparam logic [15:0] OVF_SUB_S = 16'h8000;
`else
  localparam logic [15:0] OVF_ADD_S = 16'h8000;
  localparam logic [15:0] OVF_SUB_S = 16'h7FFF;
`endif

  pipelined_add_sub_cla #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Overflow judged from operand/result signs rather than from carries.
  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic mctrl);
    res_t        r;
    logic [15:0] be;
    logic [16:0] f;
    be  = mctrl ? ~mb : mb;
    f   = {1'b0, ma} + {1'b0, be} + {16'd0, mcin ^ mctrl};
    r.s = f[15:0];
    r.c = f[16];
    r.o = (ma[15] == be[15]) && (f[15] != ma[15]);
`ifdef ADDSUB_SAT_EN
    if (r.o) r.s = f[15] ? 16'h7FFF : 16'h8000;
`endif
    r.z = (r.s == 16'h0000);
    return r;
  endfunction

  task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tcin, input logic tctrl,
                        input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    int lat;
    in_valid = 1'b1; a = ta; b = tb_; cin = tcin; ctrl = tctrl; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cin = ~tcin; ctrl = ~tctrl;
    lat = 0;
    while (lat < 20) begin
      lat++;
      @(posedge clk); #1;
      if (out_valid) break;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_s"}, s, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_zero"}, zero, ez);
  endtask

  task automatic step();
    res_t e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = q[0];
        check("s", s, e.s);
        check("cout", cout, e.c);
        check("ovf", ovf, e.o);
        check("zero", zero, e.z);
        if (out_ready) begin
          void'(q.pop_front());
          if (out_cnt == 0) first_out = cyc;
          last_out = cyc;
          out_cnt++;
        end else begin
          check("stall_in_ready", in_ready, 1'b0);
        end
      end
    end
    if (accepted) q.push_back(model(a, b, cin, ctrl));
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_stream(input int stall_at);
    int idx, guard;
    idx = 0; guard = 0; cyc = 0; out_cnt = 0; first_out = 0; last_out = 0;
    while ((idx < 8 || q.size() > 0) && guard < 100) begin
      in_valid  = (idx < 8);
      a         = 16'h1111 * idx[15:0] + 16'h0123;
      b         = 16'h0F0F ^ {idx[7:0], idx[7:0]};
      cin       = idx[1];
      ctrl      = idx[0];
      out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      step();
      if (accepted) idx++;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", out_cnt, 8);
    check("stream_drained", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; ctrl = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, 16'h0000);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    single("add_basic",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    single("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    single("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    single("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, OVF_ADD_S, 1'b0, 1'b1, 1'b0);
    single("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, OVF_SUB_S, 1'b1, 1'b1, 1'b0);
    single("sub_equal",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    single("add_cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    single("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    run_stream(-1);
    check("stream_consecutive", last_out - first_out, 7);
    run_stream(6);

    // Reset with beats in flight and the first already presented.
    q.delete();
    cyc = 0; out_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h0100 + 16'(i); b = 16'h0001; cin = 1'b0; ctrl = 1'b0;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    check("pre_reset_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", out_valid, 1'b0);
    check("mid_reset_s", s, 16'h0000);
    q.delete();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("post_reset_quiet", out_valid, 1'b0);

    // Random traffic with random backpressure.
    acc = 0;
    for (int guard = 0; guard < 60000 && acc < 10000; guard++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      ctrl      = 1'($urandom);
      step();
      if (accepted) acc++;
    end
    check("rand_accepted", acc, 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int guard = 0; guard < 50 && q.size() > 0; guard++) step();
    check("rand_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
